fetch_unit: RTL and testbench

- Instruction-fetch stage of the multicycle MIPS core. Sits directly upstream of the main control decoder.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents the latched instruction (opcode field feeds the decoder) with a valid/ready handshake.
- Computes the next PC from the branch/jump resolution returned for the instruction being retired.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake, presents the
// latched instruction downstream and steps the PC on retire using the branch/jump resolution.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_instr,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  input  logic             i_branch,
  input  logic             i_zero,
  input  logic             i_j,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_plus4,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_next_pc;
  logic        w_retire;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jump_tgt = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
  assign w_retire   = (r_state == S_HOLD) && i_instr_ready;

  // Jump wins over branch; zero only matters when branch is set.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (i_j)
      w_next_pc = w_jump_tgt;
    else if (i_branch && i_zero)
      w_next_pc = w_pc_plus4 + w_br_off;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC_W;
      r_instr   <= 32'd0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_imem_ack) begin
            r_instr <= i_imem_rdata;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_retire) begin
            r_pc      <= {w_next_pc[31:2], 2'b00};
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Request is a pure decode of the state register, forced low while reset is held.
  assign o_imem_req    = (r_state == S_REQ) && !i_rst;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized fetch/retire traffic against a PC
// model, mid-request reset and a narrow-counter instance for the wrap case.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_instr_ready;
  logic        i_branch, i_zero, i_j;

  logic        o_imem_req, o_instr_valid;
  logic [31:0] o_imem_addr, o_instr, o_pc, o_pc_plus4, o_retired;

  logic        w4_req, w4_valid;
  logic [31:0] w4_addr, w4_instr, w4_pc, w4_pc_plus4;
  logic [3:0]  w4_retired;

  always #5 i_clk = ~i_clk;

  fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_instr(o_instr), .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .i_branch(i_branch), .i_zero(i_zero), .i_j(i_j),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_retired(o_retired)
  );

  fetch_unit #(.CNT_W(4)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(w4_req), .o_imem_addr(w4_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_instr(w4_instr), .o_instr_valid(w4_valid), .i_instr_ready(i_instr_ready),
    .i_branch(i_branch), .i_zero(i_zero), .i_j(i_j),
    .o_pc(w4_pc), .o_pc_plus4(w4_pc_plus4), .o_retired(w4_retired)
  );

  typedef struct {
    logic [31:0] instr;
    int          ack_dly;
    int          rdy_dly;
    logic        br, z, j, spur;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[17];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] m_pc;
  int          m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // Flags are don't-care outside the retire cycle, so scramble them there.
  task automatic junk();
    i_branch = 1'($urandom);
    i_zero   = 1'($urandom);
    i_j      = 1'($urandom);
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic br, input logic z, input logic j);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (br && z) return seq + 32'(int'($signed(instr[15:0])) * 4);
    return seq;
  endfunction

  task automatic do_instr(input logic [31:0] instr, input int ack_dly, input int rdy_dly,
                          input logic br, input logic z, input logic j, input logic spur,
                          input logic [31:0] exp_next);
    int n;
    n = 0;
    while (!o_imem_req && n < 20) begin tick(); n++; end
    chk("req_seen", 32'(o_imem_req), 32'd1);
    chk("fetch_addr", o_imem_addr, m_pc);
    chk("pc_aligned", 32'(o_pc[1:0]), 32'd0);
    chk("valid_in_req", 32'(o_instr_valid), 32'd0);
    for (int k = 0; k < ack_dly; k++) begin
      i_instr_ready = 1'($urandom);
      junk();
      tick();
      chk("addr_stable", o_imem_addr, m_pc);
      chk("retired_stable_req", o_retired, 32'(m_ret));
    end
    i_imem_ack = 1'b1; i_imem_rdata = instr; i_instr_ready = 1'b0;
    tick();
    i_imem_ack = 1'b0; i_imem_rdata = $urandom;
    chk("instr_latch", o_instr, instr);
    chk("valid_hold", 32'(o_instr_valid), 32'd1);
    chk("req_low_hold", 32'(o_imem_req), 32'd0);
    chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
    for (int k = 0; k < rdy_dly; k++) begin
      if (spur) begin i_imem_ack = 1'b1; i_imem_rdata = ~instr; end
      junk();
      tick();
      i_imem_ack = 1'b0;
      chk("instr_stable", o_instr, instr);
      chk("pc_stable", o_pc, m_pc);
      chk("retired_stable_hold", o_retired, 32'(m_ret));
    end
    i_instr_ready = 1'b1; i_branch = br; i_zero = z; i_j = j;
    tick();
    i_instr_ready = 1'b0;
    junk();
    m_pc  = exp_next;
    m_ret = m_ret + 1;
    chk("next_pc", o_pc, exp_next);
    chk("retired", o_retired, 32'(m_ret));
    chk("retired_w4", 32'(w4_retired), 32'(m_ret % 16));
    chk("valid_after_retire", 32'(o_instr_valid), 32'd0);
  endtask

  initial begin
    int c0;
    logic [31:0] ri;
    logic rb, rz, rj;

    vecs[0]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
    vecs[3]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    vecs[4]  = '{32'h1000_0003, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020};
    vecs[5]  = '{32'h0800_0004, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[6]  = '{32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014};
    vecs[7]  = '{32'h0800_0004, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[8]  = '{32'h1000_FFFF, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010};
    vecs[9]  = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_000C};
    vecs[10] = '{32'h0000_0020, 5, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};
    vecs[11] = '{32'h0800_0000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[12] = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vecs[13] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[14] = '{32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};
    vecs[15] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000};
    vecs[16] = '{32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0100};

    i_rst = 1'b1; i_imem_ack = 1'b0; i_imem_rdata = 32'd0; i_instr_ready = 1'b0;
    i_branch = 1'b0; i_zero = 1'b0; i_j = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_retired", o_retired, 32'd0);
    i_rst = 1'b0;
    #1;
    chk("req_after_rst", 32'(o_imem_req), 32'd1);
    m_pc = 32'd0; m_ret = 0;

    c0 = cyc;
    foreach (vecs[i]) begin
      do_instr(vecs[i].instr, vecs[i].ack_dly, vecs[i].rdy_dly, vecs[i].br, vecs[i].z,
               vecs[i].j, vecs[i].spur, vecs[i].exp_pc);
      if (i == 2) chk("throughput_cycles", 32'(cyc - c0), 32'd6);
    end

    for (int i = 0; i < 40; i++) begin
      ri = $urandom; rb = 1'($urandom); rz = 1'($urandom); rj = 1'($urandom);
      do_instr(ri, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb, rz, rj,
               1'($urandom), model_next(m_pc, ri, rb, rz, rj));
    end

    // Mid-request reset with PC at 0x40, plus an ack held across the reset window.
    do_instr(32'h0800_0010, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    tick(); tick();
    chk("pre_rst_addr", o_imem_addr, 32'h0000_0040);
    i_rst = 1'b1;
    #1;
    chk("midrst_req", 32'(o_imem_req), 32'd0);
    chk("midrst_pc", o_pc, 32'd0);
    chk("midrst_retired", o_retired, 32'd0);
    chk("midrst_retired_w4", 32'(w4_retired), 32'd0);
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ack = 1'b0;
    i_rst = 1'b0;
    #1;
    chk("ack_in_rst_ignored", o_instr, 32'd0);
    chk("post_rst_addr", o_imem_addr, 32'd0);
    m_pc = 32'd0; m_ret = 0;

    for (int i = 0; i < 16; i++)
      do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
    chk("wrap_w4_zero", 32'(w4_retired), 32'd0);
    chk("wide_count_16", o_retired, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
